// File: rtl/expr_eval.sv
// expr_eval: evaluates '='-terminated ASCII expressions of digits, '+' and '*' ('*' binds tighter).
// Optional feature macro MULTI_DIGIT_EN enables multi-digit decimal operands.
module expr_eval #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             err,
  output logic             overflow,
  output logic             busy
);

`ifdef MULTI_DIGIT_EN
  localparam int OW = WIDTH;
  localparam int MW = 2 * WIDTH;
`else
  localparam int OW = 4;
  localparam int MW = WIDTH + 4;
`endif

  typedef enum logic [1:0] {EXP_NUM, EXP_OP, ERROR} state_t;

  state_t           state;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] prod;
  logic [OW-1:0]    operand;
  logic             ovf_acc;

  logic             is_digit;
  logic             is_plus;
  logic             is_star;
  logic             is_eq;
  logic [3:0]       digit;
  logic [MW-1:0]    mul_full;
  logic [WIDTH:0]   add_full;
  logic             mul_ovf;
  logic             add_ovf;

  assign is_digit = (in >= 8'h30) && (in <= 8'h39);
  assign is_plus  = (in == 8'h2B);
  assign is_star  = (in == 8'h2A);
  assign is_eq    = (in == 8'h3D);
  assign digit    = in[3:0];

  // The pending term is prod*operand; both '+' and '=' fold it into sum.
  assign mul_full = MW'(prod) * MW'(operand);
  assign mul_ovf  = |mul_full[MW-1:WIDTH];
  assign add_full = {1'b0, sum} + {1'b0, mul_full[WIDTH-1:0]};
  assign add_ovf  = add_full[WIDTH];

`ifdef MULTI_DIGIT_EN
  localparam int AW = OW + 4;
  logic [AW-1:0] acc_full;
  logic          acc_ovf;

  assign acc_full = AW'(operand) * AW'(10) + AW'(digit);
  assign acc_ovf  = |acc_full[AW-1:OW];
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state        <= EXP_NUM;
      sum          <= '0;
      prod         <= WIDTH'(1);
      operand      <= '0;
      ovf_acc      <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (in_valid) begin
        if (is_eq) begin
          result_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= EXP_NUM;
          sum          <= '0;
          prod         <= WIDTH'(1);
          operand      <= '0;
          ovf_acc      <= 1'b0;
          if (state == EXP_OP) begin
            result   <= add_full[WIDTH-1:0];
            err      <= 1'b0;
            overflow <= ovf_acc | mul_ovf | add_ovf;
          end else begin
            result   <= '0;
            err      <= 1'b1;
            overflow <= 1'b0;
          end
        end else begin
          busy <= 1'b1;
          case (state)
            EXP_NUM: begin
              if (is_digit) begin
                operand <= OW'(digit);
                state   <= EXP_OP;
              end else begin
                state <= ERROR;
              end
            end
            EXP_OP: begin
              if (is_star) begin
                prod    <= mul_full[WIDTH-1:0];
                ovf_acc <= ovf_acc | mul_ovf;
                state   <= EXP_NUM;
              end else if (is_plus) begin
                sum     <= add_full[WIDTH-1:0];
                prod    <= WIDTH'(1);
                ovf_acc <= ovf_acc | mul_ovf | add_ovf;
                state   <= EXP_NUM;
              end else if (is_digit) begin
`ifdef MULTI_DIGIT_EN
                operand <= acc_full[OW-1:0];
                ovf_acc <= ovf_acc | acc_ovf;
`else
                state <= ERROR;
`endif
              end else begin
                state <= ERROR;
              end
            end
            // ERROR swallows everything until '='
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_expr_eval.sv
// tb_expr_eval: directed and random character streams checked against a string-level expression evaluator.
module tb_expr_eval;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         in_valid;
  logic [7:0]   in_ch;
  logic [W-1:0] result;
  logic         result_valid;
  logic         err;
  logic         overflow;
  logic         busy;

  expr_eval #(.WIDTH(W)) dut (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in(in_ch),
    .result(result), .result_valid(result_valid), .err(err),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad = 0;
  byte          body_q[$];
  bit           strobe_due = 1'b0;
  logic [W-1:0] exp_res = '0;
  bit           exp_err = 1'b0;
  bit           exp_ovf = 1'b0;

  // Evaluates one expression body (chars before '='): sum of products, every step wrapped at 2^W.
  function automatic void model_eval(input byte chars[$], output logic [W-1:0] res,
                                     output bit e, output bit o);
    longint lim = longint'(1) << W;
    longint sum = 0;
    longint prod = 1;
    longint num = 0;
    int     ndig = 0;
    int     maxdig = 0;
    bit     malformed = 1'b0;
    bit     wrapped = 1'b0;
    foreach (chars[i]) begin
      int c = int'(chars[i]);
      if (c >= 48 && c <= 57) begin
        ndig++;
        if (ndig > maxdig) maxdig = ndig;
        num = num * 10 + (c - 48);
        if (num >= lim) begin wrapped = 1'b1; num = num % lim; end
      end else if (c == 43 || c == 42) begin
        if (ndig == 0) malformed = 1'b1;
        prod = prod * num;
        if (prod >= lim) begin wrapped = 1'b1; prod = prod % lim; end
        if (c == 43) begin
          sum = sum + prod;
          if (sum >= lim) begin wrapped = 1'b1; sum = sum % lim; end
          prod = 1;
        end
        num = 0;
        ndig = 0;
      end else begin
        malformed = 1'b1;
      end
    end
    if (ndig == 0) malformed = 1'b1;
    prod = prod * num;
    if (prod >= lim) begin wrapped = 1'b1; prod = prod % lim; end
    sum = sum + prod;
    if (sum >= lim) begin wrapped = 1'b1; sum = sum % lim; end
`ifndef MULTI_DIGIT_EN
    if (maxdig > 1) malformed = 1'b1;
`endif
    if (malformed) begin
      res = '0; e = 1'b1; o = 1'b0;
    end else begin
      res = sum[W-1:0]; e = 1'b0; o = wrapped;
    end
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_output(input string ctx);
    check_val({ctx, " result_valid"}, 32'(result_valid), 32'(strobe_due));
    check_val({ctx, " result"}, 32'(result), 32'(exp_res));
    check_val({ctx, " err"}, 32'(err), 32'(exp_err));
    check_val({ctx, " overflow"}, 32'(overflow), 32'(exp_ovf));
    check_val({ctx, " busy"}, 32'(busy), 32'(body_q.size() != 0));
  endtask

  // One clock: check what the previous edge produced, then present the next input.
  task automatic step(input bit v, input byte c, input string ctx);
    @(negedge clk);
    check_output(ctx);
    strobe_due = 1'b0;
    in_valid = v;
    in_ch = c;
    if (v) begin
      if (c == 8'h3D) begin
        model_eval(body_q, exp_res, exp_err, exp_ovf);
        body_q.delete();
        strobe_due = 1'b1;
      end else begin
        body_q.push_back(c);
      end
    end
  endtask

  task automatic apply_stimulus(input string s, input string ctx);
    for (int i = 0; i < s.len(); i++) step(1'b1, byte'(s.getc(i)), ctx);
  endtask

  task automatic idle(input int n, input string ctx);
    for (int i = 0; i < n; i++) step(1'b0, byte'($urandom_range(0, 255)), ctx);
  endtask

  task automatic mid_reset(input string ctx);
    @(negedge clk);
    check_output({ctx, " pre"});
    clr_n = 1'b0;
    in_valid = 1'b0;
    body_q.delete();
    strobe_due = 1'b0;
    exp_res = '0;
    exp_err = 1'b0;
    exp_ovf = 1'b0;
    #1;
    check_output({ctx, " async"});
    @(negedge clk);
    check_output({ctx, " held"});
    clr_n = 1'b1;
  endtask

  task automatic random_expr(input string ctx);
    byte q[$];
    byte junk[6] = '{8'h2B, 8'h2A, 8'h3D, 8'h61, 8'h20, 8'h2F};
    int  nterms = $urandom_range(1, 8);
    int  nd;
    for (int t = 0; t < nterms; t++) begin
`ifdef MULTI_DIGIT_EN
      nd = $urandom_range(1, 3);
`else
      nd = ($urandom_range(0, 15) == 0) ? 2 : 1;
`endif
      for (int k = 0; k < nd; k++) q.push_back(byte'(48 + $urandom_range(0, 9)));
      if (t != nterms - 1) q.push_back(($urandom_range(0, 2) == 0) ? 8'h2B : 8'h2A);
    end
    if ($urandom_range(0, 9) == 0) q[$urandom_range(0, q.size() - 1)] = junk[$urandom_range(0, 5)];
    q.push_back(8'h3D);
    foreach (q[i]) begin
      if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3), ctx);
      step(1'b1, q[i], ctx);
    end
  endtask

  initial begin
    clr_n = 1'b0;
    in_valid = 1'b0;
    in_ch = 8'h00;
    repeat (2) @(negedge clk);
    check_output("reset");
    clr_n = 1'b1;

    apply_stimulus("1+2*3=", "precedence");
    idle(2, "precedence tail");
    apply_stimulus("1+2**3=", "double op");
    apply_stimulus("4=", "after error");
    apply_stimulus("9*9*9*9*9*9=", "mul wrap");
    apply_stimulus("2+3=", "wrap cleared");
    apply_stimulus("9*9*9*9*9+9*9*9*9*9+9*9*9*9*9=", "add wrap");
    apply_stimulus("1+2", "pre reset");
    mid_reset("mid reset");
    apply_stimulus("4=", "post reset");
    apply_stimulus("3", "gap");
    idle(3, "gap");
    apply_stimulus("*5=", "gap");
    idle(2, "gap tail");
    apply_stimulus("12*3=", "two digits");
    apply_stimulus("=", "empty");
    apply_stimulus("7+=", "trailing op");
    apply_stimulus("5#3=", "illegal");
    apply_stimulus("0*9+8=", "zero factor");
    apply_stimulus("5=6*7=8+9*0=", "back to back");

    for (int n = 0; n < 300; n++) random_expr("random");
    idle(2, "final");

    $display("[TB] random and directed streams complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
